control_in_conditioner: RTL and testbench

//  Front-end conditioner for the 8-bit control input PIO (Avalon s1, readdata bit i = in_port[i]).

---
 rtl/control_in_conditioner_if.sv | 35 +++
 rtl/control_in_conditioner.sv | 107 ++++++++++
 tb/tb_control_in_conditioner.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/control_in_conditioner_if.sv
// Signal bundle between the raw DE2 control pins / CPU-side control PIOs and
// the control input conditioner.
//   key_n   : raw pushbuttons, asynchronous, 0 = pressed
//   sw      : raw slide switches, asynchronous, 1 = on
//   clr_i   : key flag clear mask, synchronous to clk, level-acting
//   irq_en  : per-key interrupt enable, synchronous to clk
//   in_port : {sw_db[3:0], key_flag[3:0]} towards the control-input PIO
//   irq     : level interrupt, high while any enabled flag is pending
// slave modport is the conditioner side, master is the pin/CPU side.
interface control_in_conditioner_if;
    logic [3:0] key_n;
    logic [3:0] sw;
    logic [3:0] clr_i;
    logic [3:0] irq_en;
    logic [7:0] in_port;
    logic       irq;

    modport master (
        output key_n,
        output sw,
        output clr_i,
        output irq_en,
        input  in_port,
        input  irq
    );

    modport slave (
        input  key_n,
        input  sw,
        input  clr_i,
        input  irq_en,
        output in_port,
        output irq
    );
endinterface

// File: rtl/control_in_conditioner.sv
// Front-end conditioner for the 8-bit control input PIO.
// Each of the eight pins (4 active-low keys, 4 switches) is synchronised and
// debounced; debounced key presses set sticky flags that the CPU clears with
// clr_i, and irq is raised while any enabled flag is pending.
// Ports:
//   clk     : system clock (50 MHz)
//   reset_n : asynchronous active-low reset
//   bus_if  : slave side of control_in_conditioner_if (pins in, in_port/irq out)
module control_in_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic                      clk,
    input  logic                      reset_n,
    control_in_conditioner_if.slave   bus_if
);

    localparam int              NPIN    = 8;
    // Keys idle high (released), switches idle low.
    localparam logic [NPIN-1:0] PIN_RST = 8'h0F;
    localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NPIN-1:0]  pin_raw;
    logic [NPIN-1:0]  sync_q [SYNC_STAGES];
    logic [NPIN-1:0]  sync_s;

    logic [NPIN-1:0]  db_q, db_d;
    logic [NPIN-1:0]  upd_q, upd_d;
    logic [CNT_W-1:0] cnt_q [NPIN];
    logic [CNT_W-1:0] cnt_d [NPIN];

    logic [3:0]       press;
    logic [3:0]       flag_q, flag_d;
    logic             irq_q, irq_d;

    assign pin_raw = {bus_if.sw, bus_if.key_n};
    assign sync_s  = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= PIN_RST;
            end
        end else begin
            sync_q[0] <= pin_raw;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // A new level is accepted after DEBOUNCE_CYCLES consecutive cycles of
    // disagreement; any agreement clears the count. The >= compare keeps the
    // counter from ever wrapping.
    always_comb begin
        db_d  = db_q;
        upd_d = '0;
        for (int i = 0; i < NPIN; i++) begin
            cnt_d[i] = '0;
            if (sync_s[i] != db_q[i]) begin
                if (cnt_q[i] >= CNT_TC) begin
                    db_d[i]  = sync_s[i];
                    upd_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_q  <= PIN_RST;
            upd_q <= '0;
            for (int i = 0; i < NPIN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            db_q  <= db_d;
            upd_q <= upd_d;
            for (int i = 0; i < NPIN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // A press is a debounce update that left the key low; set beats clear.
    assign press  = upd_q[3:0] & ~db_q[3:0];
    assign flag_d = press | (flag_q & ~bus_if.clr_i);
    assign irq_d  = |(flag_q & bus_if.irq_en);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flag_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            flag_q <= flag_d;
            irq_q  <= irq_d;
        end
    end

    assign bus_if.in_port = {db_q[7:4], flag_q};
    assign bus_if.irq     = irq_q;

endmodule

// File: tb/tb_control_in_conditioner.sv
module tb_control_in_conditioner;

    typedef struct {
        int         cyc;
        logic [7:0] port;
        logic       irq;
    } exp_t;

    logic clk;
    logic reset_n;
    int   cyc;
    int   tests;
    int   fails;
    exp_t exp_q[$];

    control_in_conditioner_if bus ();

    control_in_conditioner #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus_if  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Inputs change 1 time unit after a rising edge, so the next edge is the
    // first one to sample them.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_at(input int dly, input logic [7:0] port, input logic irq);
        exp_t e;
        e.cyc  = cyc + dly;
        e.port = port;
        e.irq  = irq;
        exp_q.push_back(e);
    endtask

    task automatic check_now(input string name, input logic [7:0] port, input logic irq);
        tests++;
        if (bus.in_port !== port || bus.irq !== irq) begin
            fails++;
            $display("FAIL %s: got in_port=%h irq=%b, want in_port=%h irq=%b",
                     name, bus.in_port, bus.irq, port, irq);
        end
    endtask

    // Monitor: every change of {in_port, irq} must match the next queued
    // expectation in value and in the cycle it appears.
    logic [8:0] prev_obs;
    initial prev_obs = 9'h000;
    always @(negedge clk) begin
        logic [8:0] cur;
        exp_t e;
        cur = {bus.in_port, bus.irq};
        if (cur !== prev_obs) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_change: got in_port=%h irq=%b at cycle %0d, want no change",
                         bus.in_port, bus.irq, cyc);
            end else begin
                e = exp_q.pop_front();
                if (bus.in_port !== e.port || bus.irq !== e.irq || cyc != e.cyc) begin
                    fails++;
                    $display("FAIL output_event: got in_port=%h irq=%b at cycle %0d, want in_port=%h irq=%b at cycle %0d",
                             bus.in_port, bus.irq, cyc, e.port, e.irq, e.cyc);
                end
            end
            prev_obs = cur;
        end
    end

    initial begin
        tests        = 0;
        fails        = 0;
        reset_n      = 1'b0;
        bus.key_n    = 4'hF;
        bus.sw       = 4'h0;
        bus.clr_i    = 4'h0;
        bus.irq_en   = 4'h0;

        // 1: reset held for 20 cycles
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check_now("reset_hold", 8'h00, 1'b0);
        end
        reset_n = 1'b1;
        tick(5);
        check_now("post_reset_idle", 8'h00, 1'b0);

        // 2: clean press of key 0, flag after 7 edges, survives release
        bus.key_n = 4'hE;
        expect_at(7, 8'h01, 1'b0);
        tick(10);
        bus.key_n = 4'hF;
        tick(10);
        check_now("key0_release_sticky", 8'h01, 1'b0);

        // 3: 3-cycle glitch rejected, 4-cycle pulse accepted
        bus.key_n = 4'hD;
        tick(3);
        bus.key_n = 4'hF;
        tick(10);
        check_now("key1_glitch3", 8'h01, 1'b0);
        bus.key_n = 4'hD;
        expect_at(7, 8'h03, 1'b0);
        tick(4);
        bus.key_n = 4'hF;
        tick(12);

        // 4: single-cycle clear of flag 0
        bus.clr_i = 4'b0001;
        expect_at(1, 8'h02, 1'b0);
        tick(1);
        bus.clr_i = 4'b0000;
        tick(3);
        // clear held on key 1 while it is pressed: clears now, press sets it back
        bus.key_n = 4'hD;
        bus.clr_i = 4'b0010;
        expect_at(1, 8'h00, 1'b0);
        expect_at(7, 8'h02, 1'b0);
        tick(7);
        bus.clr_i = 4'b0000;
        bus.key_n = 4'hF;
        tick(10);
        // clear on an already-clear flag does nothing
        bus.clr_i = 4'b0001;
        tick(2);
        bus.clr_i = 4'b0000;
        tick(3);
        check_now("clear_zero_flag", 8'h02, 1'b0);

        // 5: switch 2 on after 6 edges, then bounce every 2 cycles
        bus.sw = 4'h4;
        expect_at(6, 8'h42, 1'b0);
        tick(10);
        for (int i = 0; i < 4; i++) begin
            bus.sw = 4'h0;
            tick(2);
            bus.sw = 4'h4;
            tick(2);
        end
        tick(10);
        check_now("sw2_bounce", 8'h42, 1'b0);

        // 6: enabled key 2 press -> flag after 7 edges, irq one edge later
        bus.irq_en = 4'b0100;
        bus.key_n  = 4'hB;
        expect_at(7, 8'h46, 1'b0);
        expect_at(8, 8'h46, 1'b1);
        tick(8);
        bus.key_n = 4'hF;
        tick(10);
        // reset in the middle of a key 3 debounce
        bus.key_n = 4'h7;
        tick(3);
        reset_n = 1'b0;
        expect_at(0, 8'h00, 1'b0);
        #1;
        check_now("async_reset_now", 8'h00, 1'b0);
        tick(5);
        bus.key_n = 4'hF;
        tick(1);
        reset_n = 1'b1;
        // switch 2 is still on and must re-qualify from scratch
        expect_at(6, 8'h40, 1'b0);
        tick(15);
        check_now("after_reset_release", 8'h40, 1'b0);

        tick(2);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL missing_events: got %0d expected events never seen, want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
